// File: rtl/frame_average_mc_if.sv
// Beat-in / result-out bundle of the multi-channel frame averager.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; the producer holds payload stable while valid && !ready.
interface frame_average_mc_if #(
  parameter int DATA_W = 54,
  parameter int CH_N   = 4,
  parameter int CNT_W  = 10
);
  logic [CH_N*DATA_W-1:0] data_in;
  logic                   in_sof;
  logic                   in_eof;
  logic                   in_valid;
  logic                   in_ready;
  logic [CH_N*DATA_W-1:0] avg_out;
  logic [CNT_W-1:0]       cnt_out;
  logic                   out_trunc;
  logic                   out_restart;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output data_in, in_sof, in_eof, in_valid, out_ready,
    input  in_ready, avg_out, cnt_out, out_trunc, out_restart, out_valid
  );

  modport slave (
    input  data_in, in_sof, in_eof, in_valid, out_ready,
    output in_ready, avg_out, cnt_out, out_trunc, out_restart, out_valid
  );
endinterface

// File: rtl/frame_average_mc.sv
// Frame averager: sums CH_N signed samples per frame, then divides each sum by
// the beat count with a restoring shift-subtract divider, one channel at a time.
module frame_average_mc #(
  parameter int DATA_W  = 54,
  parameter int CH_N    = 4,
  parameter int CNT_W   = 10,
  parameter int MAX_CNT = 1001,
  parameter int ROUND   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_average_mc_if.slave bus,
  output logic [1:0]        state_dbg
);
  localparam int ACC_W  = DATA_W + CNT_W;
  localparam int STEP_W = $clog2(ACC_W + 1);
  localparam int CH_W   = (CH_N > 1) ? $clog2(CH_N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DIV = 2'd2, OUT = 2'd3} state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0]       acc [CH_N];
  logic [CNT_W-1:0]       cnt_q;
  logic                   trunc_q, restart_q;
  logic [CH_N*DATA_W-1:0] avg_q;

  logic [ACC_W-1:0]  quo_q;
  logic [CNT_W-1:0]  rem_q;
  logic              neg_q;
  logic [STEP_W-1:0] step_q;
  logic [CH_W-1:0]   ch_q;

  logic             in_ready_c, out_valid_c, accept, at_max, closing, div_done;
  logic [CNT_W-1:0] load_cnt;

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] d);
    return {{CNT_W{d[DATA_W-1]}}, d};
  endfunction

  // Count after this beat: a sof restarts at 1, anything else increments.
  assign accept   = bus.in_valid && in_ready_c;
  assign load_cnt = bus.in_sof ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign at_max   = (load_cnt == CNT_W'(MAX_CNT));
  assign closing  = bus.in_eof || at_max;
  assign div_done = (state_q == DIV) && (step_q == STEP_W'(ACC_W)) && (ch_q == CH_W'(CH_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && bus.in_sof) state_d = closing ? DIV : ACCUM;
      ACCUM:   if (accept && closing)    state_d = DIV;
      DIV:     if (div_done)             state_d = OUT;
      OUT:     if (bus.out_ready)        state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_q == IDLE) || (state_q == ACCUM);
    out_valid_c = (state_q == OUT);
    state_dbg   = state_q;
  end

  // Frame accumulation; beats without sof are ignored while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_N; c++) acc[c] <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      restart_q <= 1'b0;
    end else if (accept && (bus.in_sof || state_q == ACCUM)) begin
      for (int c = 0; c < CH_N; c++)
        acc[c] <= bus.in_sof ? sext(bus.data_in[c*DATA_W +: DATA_W])
                             : acc[c] + sext(bus.data_in[c*DATA_W +: DATA_W]);
      cnt_q   <= load_cnt;
      trunc_q <= at_max && !bus.in_eof;
      if (bus.in_sof) restart_q <= (state_q == ACCUM);
    end
  end

  logic [ACC_W-1:0] acc_sel, abs_in, quo_nx, mag, res;
  logic [CNT_W:0]   trial, diff;
  logic [CNT_W-1:0] rem_nx;
  logic             ge, round_up;

  always_comb begin
    acc_sel  = acc[ch_q];
    abs_in   = acc_sel[ACC_W-1] ? (~acc_sel + ACC_W'(1)) : acc_sel;
    trial    = {rem_q, quo_q[ACC_W-1]};
    diff     = trial - {1'b0, cnt_q};
    ge       = (trial >= {1'b0, cnt_q});
    rem_nx   = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    quo_nx   = {quo_q[ACC_W-2:0], ge};
    round_up = (ROUND != 0) && ({rem_nx, 1'b0} >= {1'b0, cnt_q});
    mag      = quo_nx + ACC_W'(round_up);
    res      = neg_q ? (~mag + ACC_W'(1)) : mag;
  end

  // Step 0 loads |acc| of the current channel, steps 1..ACC_W each retire one quotient bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      neg_q  <= 1'b0;
      step_q <= '0;
      ch_q   <= '0;
      avg_q  <= '0;
    end else if (state_q == DIV) begin
      if (step_q == '0) begin
        quo_q  <= abs_in;
        rem_q  <= '0;
        neg_q  <= acc_sel[ACC_W-1];
        step_q <= STEP_W'(1);
      end else begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
        if (step_q == STEP_W'(ACC_W)) begin
          avg_q[ch_q*DATA_W +: DATA_W] <= res[DATA_W-1:0];
          step_q <= '0;
          ch_q   <= (ch_q == CH_W'(CH_N - 1)) ? '0 : ch_q + CH_W'(1);
        end else begin
          step_q <= step_q + STEP_W'(1);
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.avg_out     = avg_q;
  assign bus.cnt_out     = cnt_q;
  assign bus.out_trunc   = trunc_q;
  assign bus.out_restart = restart_q;
endmodule

// File: tb/tb_frame_average_mc.sv
// Directed bench for frame_average_mc: one truncating DUT and one rounding DUT
// share the same stimulus; expected means are hand-computed constants.
module tb_frame_average_mc;
  localparam int DATA_W  = 54;
  localparam int CH_N    = 2;
  localparam int CNT_W   = 10;
  localparam int MAX_CNT = 1001;
  localparam logic signed [DATA_W-1:0] MIN54 = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX54 = {1'b0, {(DATA_W-1){1'b1}}};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_average_mc_if #(.DATA_W(DATA_W), .CH_N(CH_N), .CNT_W(CNT_W)) bus ();
  frame_average_mc_if #(.DATA_W(DATA_W), .CH_N(CH_N), .CNT_W(CNT_W)) bus_r ();
  logic [1:0] st_dbg, st_dbg_r;

  frame_average_mc #(.DATA_W(DATA_W), .CH_N(CH_N), .CNT_W(CNT_W), .MAX_CNT(MAX_CNT), .ROUND(0))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .state_dbg(st_dbg));
  frame_average_mc #(.DATA_W(DATA_W), .CH_N(CH_N), .CNT_W(CNT_W), .MAX_CNT(MAX_CNT), .ROUND(1))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r.slave), .state_dbg(st_dbg_r));

  assign bus_r.data_in   = bus.data_in;
  assign bus_r.in_sof    = bus.in_sof;
  assign bus_r.in_eof    = bus.in_eof;
  assign bus_r.in_valid  = bus.in_valid;
  assign bus_r.out_ready = bus.out_ready;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DATA_W-1:0] ch(input logic [CH_N*DATA_W-1:0] v, input int i);
    return v[i*DATA_W +: DATA_W];
  endfunction

  // driver tasks
  task automatic send_beat(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                           input logic sof, input logic eof);
    int guard = 0;
    bus.data_in  = {b, a};
    bus.in_sof   = sof;
    bus.in_eof   = eof;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_beat_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
  endtask

  // Counts cycles from the closing beat's acceptance edge to out_valid.
  task automatic wait_out(output int cycles);
    cycles = 1;
    while (bus.out_valid !== 1'b1 && cycles < 2000) begin
      @(posedge clk); #1; cycles++;
    end
    if (bus.out_valid !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL wait_out_timeout out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    bus.data_in = '0; bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.avg_out !== '0) begin n_err++; $display("FAIL rst_avg got %h want 0", bus.avg_out); end
    n_cmp++; if (bus.cnt_out !== '0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", bus.cnt_out); end
    n_cmp++; if ({bus.out_trunc, bus.out_restart} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {bus.out_trunc, bus.out_restart}); end
    n_cmp++; if (st_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", st_dbg); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int cyc;
    send_beat(10, -1, 1'b1, 1'b0);
    send_beat(20, -2, 1'b0, 1'b0);
    send_beat(30, -3, 1'b0, 1'b0);
    send_beat(40, -4, 1'b0, 1'b1);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL norm_div_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (st_dbg !== 2'd2) begin n_err++; $display("FAIL norm_div_state got %0d want 2", st_dbg); end
    wait_out(cyc);
    n_cmp++; if (cyc != 131) begin n_err++; $display("FAIL norm_latency got %0d want 131", cyc); end
    n_cmp++; if (ch(bus.avg_out, 0) !== 54'(25)) begin n_err++; $display("FAIL norm_ch0 got %0d want 25", $signed(ch(bus.avg_out, 0))); end
    n_cmp++; if (ch(bus.avg_out, 1) !== 54'(-2)) begin n_err++; $display("FAIL norm_ch1 got %0d want -2", $signed(ch(bus.avg_out, 1))); end
    n_cmp++; if (bus.cnt_out !== 10'd4) begin n_err++; $display("FAIL norm_cnt got %0d want 4", bus.cnt_out); end
    n_cmp++; if ({bus.out_trunc, bus.out_restart} !== 2'b00) begin n_err++; $display("FAIL norm_flags got %b want 00", {bus.out_trunc, bus.out_restart}); end
    n_cmp++; if (ch(bus_r.avg_out, 0) !== 54'(25)) begin n_err++; $display("FAIL norm_round_ch0 got %0d want 25", $signed(ch(bus_r.avg_out, 0))); end
    n_cmp++; if (ch(bus_r.avg_out, 1) !== 54'(-3)) begin n_err++; $display("FAIL norm_round_ch1 got %0d want -3", $signed(ch(bus_r.avg_out, 1))); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL norm_consumed_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL norm_consumed_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    int cyc;
    send_beat(MIN54, MAX54, 1'b1, 1'b1);
    wait_out(cyc);
    n_cmp++; if (ch(bus.avg_out, 0) !== MIN54) begin n_err++; $display("FAIL single_ch0 got %h want %h", ch(bus.avg_out, 0), MIN54); end
    n_cmp++; if (ch(bus.avg_out, 1) !== MAX54) begin n_err++; $display("FAIL single_ch1 got %h want %h", ch(bus.avg_out, 1), MAX54); end
    n_cmp++; if (ch(bus_r.avg_out, 0) !== MIN54) begin n_err++; $display("FAIL single_round_ch0 got %h want %h", ch(bus_r.avg_out, 0), MIN54); end
    n_cmp++; if (bus.cnt_out !== 10'd1) begin n_err++; $display("FAIL single_cnt got %0d want 1", bus.cnt_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_trunc();
    int cyc;
    for (int i = 0; i < MAX_CNT; i++) send_beat(7, -7, (i == 0), 1'b0);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL trunc_beat1002_in_ready got %b want 0", bus.in_ready); end
    bus.data_in = {54'(-500), 54'(500)};
    bus.in_valid = 1'b1;
    wait_out(cyc);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_trunc !== 1'b1) begin n_err++; $display("FAIL trunc_flag got %b want 1", bus.out_trunc); end
    n_cmp++; if (bus.cnt_out !== 10'd1001) begin n_err++; $display("FAIL trunc_cnt got %0d want 1001", bus.cnt_out); end
    n_cmp++; if (ch(bus.avg_out, 0) !== 54'(7)) begin n_err++; $display("FAIL trunc_ch0 got %0d want 7", $signed(ch(bus.avg_out, 0))); end
    n_cmp++; if (ch(bus.avg_out, 1) !== 54'(-7)) begin n_err++; $display("FAIL trunc_ch1 got %0d want -7", $signed(ch(bus.avg_out, 1))); end
    n_cmp++; if (bus.out_restart !== 1'b0) begin n_err++; $display("FAIL trunc_restart got %b want 0", bus.out_restart); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart();
    int cyc;
    send_beat(100, -100, 1'b1, 1'b0);
    send_beat(100, -100, 1'b0, 1'b0);
    send_beat(100, -100, 1'b0, 1'b0);
    send_beat(5, -5, 1'b1, 1'b0);
    send_beat(9, -9, 1'b0, 1'b1);
    wait_out(cyc);
    n_cmp++; if (ch(bus.avg_out, 0) !== 54'(7)) begin n_err++; $display("FAIL restart_ch0 got %0d want 7", $signed(ch(bus.avg_out, 0))); end
    n_cmp++; if (ch(bus.avg_out, 1) !== 54'(-7)) begin n_err++; $display("FAIL restart_ch1 got %0d want -7", $signed(ch(bus.avg_out, 1))); end
    n_cmp++; if (bus.cnt_out !== 10'd2) begin n_err++; $display("FAIL restart_cnt got %0d want 2", bus.cnt_out); end
    n_cmp++; if (bus.out_restart !== 1'b1) begin n_err++; $display("FAIL restart_flag got %b want 1", bus.out_restart); end
    @(posedge clk); #1;
    send_beat(1, -1, 1'b1, 1'b0);
    send_beat(3, -3, 1'b0, 1'b1);
    wait_out(cyc);
    n_cmp++; if (bus.out_restart !== 1'b0) begin n_err++; $display("FAIL restart_next_flag got %b want 0", bus.out_restart); end
    n_cmp++; if (ch(bus.avg_out, 0) !== 54'(2)) begin n_err++; $display("FAIL restart_next_ch0 got %0d want 2", $signed(ch(bus.avg_out, 0))); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad_valid = 0;
    int bad_avg = 0;
    int bad_ready = 0;
    bus.out_ready = 1'b0;
    send_beat(8, -8, 1'b1, 1'b0);
    send_beat(12, -12, 1'b0, 1'b1);
    wait_out(cyc);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1) bad_valid++;
      if (bus.avg_out !== {54'(-10), 54'(10)}) bad_avg++;
      if (bus.in_ready !== 1'b0) bad_ready++;
    end
    n_cmp++; if (bad_valid != 0) begin n_err++; $display("FAIL bp_valid_held dropped %0d cycles want 0", bad_valid); end
    n_cmp++; if (bad_avg != 0) begin n_err++; $display("FAIL bp_avg_stable wrong %0d cycles want 0", bad_avg); end
    n_cmp++; if (bad_ready != 0) begin n_err++; $display("FAIL bp_in_ready_low wrong %0d cycles want 0", bad_ready); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    send_beat(100, -100, 1'b1, 1'b1);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
    n_cmp++; if ({bus.avg_out, bus.cnt_out, bus.out_trunc, bus.out_restart} !== '0) begin n_err++; $display("FAIL mid_rst_outputs got %h/%0d want 0", bus.avg_out, bus.cnt_out); end
    n_cmp++; if (st_dbg !== 2'd0) begin n_err++; $display("FAIL mid_rst_state got %0d want 0", st_dbg); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(4, -4, 1'b1, 1'b0);
    send_beat(6, -6, 1'b0, 1'b1);
    wait_out(cyc);
    n_cmp++; if (ch(bus.avg_out, 0) !== 54'(5)) begin n_err++; $display("FAIL post_rst_ch0 got %0d want 5", $signed(ch(bus.avg_out, 0))); end
    n_cmp++; if (ch(bus.avg_out, 1) !== 54'(-5)) begin n_err++; $display("FAIL post_rst_ch1 got %0d want -5", $signed(ch(bus.avg_out, 1))); end
    n_cmp++; if (bus.cnt_out !== 10'd2) begin n_err++; $display("FAIL post_rst_cnt got %0d want 2", bus.cnt_out); end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_single();
    test_trunc();
    test_restart();
    test_backpressure();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
